// File: rtl/sym_fir_serial_ctrl.sv
// Sequencer for a folded even-length symmetric FIR: one pre-adder and one multiplier step through N_COEFFS pairs.
// Define SYM_FIR_CTRL_ROUND_SAT_EN for round-half-up, output saturation and a sat_flag output.
module sym_fir_serial_ctrl #(
  parameter int INPUT_WORD_SIZE = 16,
  parameter int COEFF_WORD_SIZE = 16,
  parameter int N_COEFFS        = 5,
  parameter logic signed [N_COEFFS-1:0][COEFF_WORD_SIZE-1:0] COEFFS = '0,
  parameter int OUT_WORD_SIZE   = 32,
  parameter int OUT_SHIFT       = 0
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic                              clear,
  input  logic signed [INPUT_WORD_SIZE-1:0] s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic signed [OUT_WORD_SIZE-1:0]   m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              busy,
`ifdef SYM_FIR_CTRL_ROUND_SAT_EN
  output logic                              sat_flag,
`endif
  output logic [1:0]                        dbg_state
);
  // Handshake: a word moves on a rising edge where valid and ready are both high;
  // m_data/m_valid hold steady while m_valid=1 and m_ready=0.

  localparam int ACC_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(N_COEFFS) + 1;
  localparam int N_TAPS = 2 * N_COEFFS;
  localparam int KW     = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;
  localparam int SW     = $clog2(N_TAPS);
  localparam int PRE_W  = INPUT_WORD_SIZE + 1;
  localparam int PROD_W = PRE_W + COEFF_WORD_SIZE;
  localparam int EXT_W  = ((ACC_WORD_SIZE + 1 > OUT_WORD_SIZE) ? ACC_WORD_SIZE + 1 : OUT_WORD_SIZE) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                            r_state;
  logic signed [INPUT_WORD_SIZE-1:0] r_s [0:N_TAPS-1];
  logic signed [ACC_WORD_SIZE-1:0]   r_acc;
  logic [KW-1:0]                     r_k;
  logic signed [OUT_WORD_SIZE-1:0]   r_m_data;
  logic                              r_m_valid;

  logic [SW-1:0]                     w_lo_idx;
  logic [SW-1:0]                     w_hi_idx;
  logic signed [INPUT_WORD_SIZE-1:0] w_lo;
  logic signed [INPUT_WORD_SIZE-1:0] w_hi;
  logic signed [PRE_W-1:0]           w_pre;
  logic signed [COEFF_WORD_SIZE-1:0] w_coef;
  logic signed [PROD_W-1:0]          w_prod;
  logic signed [ACC_WORD_SIZE-1:0]   w_acc_next;
  logic signed [EXT_W-1:0]           w_ext;
  logic signed [EXT_W-1:0]           w_shf;
  logic [OUT_WORD_SIZE-1:0]          w_out;
  logic                              w_unused_bits;

  always_comb begin
    w_lo_idx   = SW'(r_k);
    w_hi_idx   = SW'(N_TAPS - 1) - SW'(r_k);
    w_lo       = r_s[w_lo_idx];
    w_hi       = r_s[w_hi_idx];
    w_pre      = {w_lo[INPUT_WORD_SIZE-1], w_lo} + {w_hi[INPUT_WORD_SIZE-1], w_hi};
    w_coef     = COEFFS[r_k];
    w_prod     = PROD_W'(w_pre) * PROD_W'(w_coef);
    w_acc_next = r_acc + ACC_WORD_SIZE'(w_prod);
    w_ext      = EXT_W'(w_acc_next);
  end

`ifdef SYM_FIR_CTRL_ROUND_SAT_EN
  localparam logic signed [EXT_W-1:0] RND     = (EXT_W'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_WORD_SIZE+1){1'b0}}, {(OUT_WORD_SIZE-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_WORD_SIZE+1){1'b1}}, {(OUT_WORD_SIZE-1){1'b0}}};

  logic w_sat;
  logic r_sat_flag;

  always_comb begin
    w_shf = (w_ext + RND) >>> OUT_SHIFT;
    w_sat = 1'b0;
    w_out = w_shf[OUT_WORD_SIZE-1:0];
    if (w_shf > SAT_MAX) begin
      w_sat = 1'b1;
      w_out = SAT_MAX[OUT_WORD_SIZE-1:0];
    end else if (w_shf < SAT_MIN) begin
      w_sat = 1'b1;
      w_out = SAT_MIN[OUT_WORD_SIZE-1:0];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sat_flag <= 1'b0;
    end else if (!clear && r_state == ST_MAC && r_k == KW'(N_COEFFS - 1)) begin
      r_sat_flag <= w_sat;
    end
  end

  assign sat_flag = r_sat_flag;
`else
  // Plain truncating shift; dropping MSBs gives two's-complement wrap, and the
  // wide intermediate supplies sign extension when the output is wider.
  always_comb begin
    w_shf = w_ext >>> OUT_SHIFT;
    w_out = w_shf[OUT_WORD_SIZE-1:0];
  end
`endif

  assign w_unused_bits = ^w_shf[EXT_W-1:OUT_WORD_SIZE];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= ST_IDLE;
      for (int i = 0; i < N_TAPS; i++) r_s[i] <= '0;
      r_acc     <= '0;
      r_k       <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else if (clear) begin
      r_state   <= ST_IDLE;
      for (int i = 0; i < N_TAPS; i++) r_s[i] <= '0;
      r_acc     <= '0;
      r_k       <= '0;
      r_m_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            for (int i = N_TAPS - 1; i > 0; i--) r_s[i] <= r_s[i-1];
            r_s[0]  <= s_data;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          // The last pair's product goes straight into the output register.
          if (r_k == KW'(N_COEFFS - 1)) begin
            r_m_data  <= w_out;
            r_m_valid <= 1'b1;
            r_state   <= ST_OUT;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready   = arst_n & (r_state == ST_IDLE) & ~clear;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign busy      = (r_state == ST_MAC) || (r_state == ST_OUT);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sym_fir_serial_ctrl.sv
// Bench for sym_fir_serial_ctrl (N_COEFFS=3, COEFFS={1,2,3}); the SYM_FIR_CTRL_ROUND_SAT_EN build adds a rounding/saturation instance.
module tb_sym_fir_serial_ctrl;
  localparam int IW = 16;
  localparam int CW = 16;
  localparam int N  = 3;
  localparam int OW = 32;
  localparam logic signed [N-1:0][CW-1:0] COEFFS = {16'sd3, 16'sd2, 16'sd1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic clear = 1'b0;
  logic signed [IW-1:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic signed [OW-1:0] m_data;
  logic m_valid;
  logic m_ready = 1'b1;
  logic busy;
  logic [1:0] dbg_state;
`ifdef SYM_FIR_CTRL_ROUND_SAT_EN
  logic sat_flag;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sym_fir_serial_ctrl #(
    .INPUT_WORD_SIZE(IW), .COEFF_WORD_SIZE(CW), .N_COEFFS(N),
    .COEFFS(COEFFS), .OUT_WORD_SIZE(OW), .OUT_SHIFT(0)
  ) dut (
    .clk(clk), .arst_n(arst_n), .clear(clear),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy),
`ifdef SYM_FIR_CTRL_ROUND_SAT_EN
    .sat_flag(sat_flag),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];
  int hs_q[$];
  logic pending = 1'b0;
  logic [OW-1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on each new m_valid, stability while held, data on each transfer.
  always @(negedge clk) begin
    if (!arst_n) begin
      pending = 1'b0;
    end else begin
      if (m_valid && !pending) begin
        pending = 1'b1;
        held = m_data;
        check("hs_pending", hs_q.size() > 0, 1);
        if (hs_q.size() > 0) check("latency", cyc - hs_q.pop_front(), N + 1);
      end else if (m_valid && pending) begin
        check("hold_data", m_data, held);
      end
      if (m_valid && m_ready) begin
        check("exp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("m_data", m_data, exp_q.pop_front());
        pending = 1'b0;
      end
      if (!m_valid) pending = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic signed [IW-1:0] v, input bit exp_valid, input bit exp_xfer,
                      input logic [OW-1:0] exp_val);
    int n = 0;
    s_data  = v;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", s_ready, 1);
    if (s_ready) begin
      if (exp_valid) hs_q.push_back(cyc);
      if (exp_xfer) exp_q.push_back(exp_val);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, m_valid, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_impulse();
    logic [OW-1:0] imp_exp [7];
    imp_exp = '{1, 2, 3, 3, 2, 1, 0};
    for (int i = 0; i < 7; i++) send((i == 0) ? 16'sd1 : 16'sd0, 1'b1, 1'b1, imp_exp[i]);
  endtask

`ifdef SYM_FIR_CTRL_ROUND_SAT_EN
  localparam logic signed [N-1:0][CW-1:0] RS_COEFFS = {16'sd0, 16'sd0, 16'sd1};
  logic rs_clear = 1'b0;
  logic signed [IW-1:0] rs_s_data = '0;
  logic rs_s_valid = 1'b0;
  logic rs_s_ready;
  logic signed [7:0] rs_m_data;
  logic rs_m_valid;
  logic rs_busy;
  logic rs_sat;
  logic [1:0] rs_state;

  sym_fir_serial_ctrl #(
    .INPUT_WORD_SIZE(IW), .COEFF_WORD_SIZE(CW), .N_COEFFS(N),
    .COEFFS(RS_COEFFS), .OUT_WORD_SIZE(8), .OUT_SHIFT(1)
  ) dut_rs (
    .clk(clk), .arst_n(arst_n), .clear(rs_clear),
    .s_data(rs_s_data), .s_valid(rs_s_valid), .s_ready(rs_s_ready),
    .m_data(rs_m_data), .m_valid(rs_m_valid), .m_ready(1'b1),
    .busy(rs_busy), .sat_flag(rs_sat), .dbg_state(rs_state)
  );

  task automatic rs_run(input logic signed [IW-1:0] v, input logic [7:0] exp_d, input logic exp_s);
    int n = 0;
    rs_s_data  = v;
    rs_s_valid = 1'b1;
    @(posedge clk);
    #1;
    rs_s_valid = 1'b0;
    @(negedge clk);
    while (!rs_m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rs_valid", rs_m_valid, 1);
    check("rs_data", rs_m_data, exp_d);
    check("rs_sat", rs_sat, exp_s);
    @(posedge clk);
    #1;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    #10;
    arst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // Impulse response.
    send_impulse();
    wait_drain();

    // Step response of constant 100.
    begin
      logic [OW-1:0] step_exp [8];
      step_exp = '{100, 300, 600, 900, 1100, 1200, 1200, 1200};
      for (int i = 0; i < 8; i++) send(16'sd100, 1'b1, 1'b1, step_exp[i]);
    end
    wait_drain();

    // Back-pressure: store becomes [10,100x5] -> 1110, then [20,10,100x4] -> 940.
    m_ready = 1'b0;
    send(16'sd10, 1'b1, 1'b1, 1110);
    fork
      send(16'sd20, 1'b1, 1'b1, 940);
      begin
        wait_valid("bp_valid_rise");
        repeat (10) begin
          @(negedge clk);
          check("bp_valid", m_valid, 1);
          check("bp_s_ready", s_ready, 0);
          check("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain();

    // Clear during MAC aborts the sample and flushes the store.
    send(16'sd50, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    clear = 1'b1;
    check("clr_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clr_state", dbg_state, 0);
    check("clr_m_valid", m_valid, 0);
    check("clr_busy", busy, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    send_impulse();
    wait_drain();

    // Asynchronous reset while an output is held.
    m_ready = 1'b0;
    send(16'sd5, 1'b1, 1'b0, 0);
    wait_valid("ar_valid_rise");
    #1;
    arst_n = 1'b0;
    #1;
    check("ar_m_valid", m_valid, 0);
    check("ar_m_data", m_data, 0);
    check("ar_s_ready", s_ready, 0);
    check("ar_state", dbg_state, 0);
    #1;
    arst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("ar_s_ready_after", s_ready, 1);
    @(posedge clk);
    #1;
    send(16'sd4, 1'b1, 1'b1, 4);
    wait_drain();

`ifdef SYM_FIR_CTRL_ROUND_SAT_EN
    rs_run(16'sd32767, 8'd127, 1'b1);
    rs_clear = 1'b1;
    @(posedge clk);
    #1;
    rs_clear = 1'b0;
    rs_run(16'sd3, 8'd2, 1'b0);
`endif

    check("hs_q_empty", hs_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
